// File: rtl/bpsk_correlator_demod_pkg.sv
// Shared definitions for the BPSK correlator demodulator: accumulator sizing
// and the decision-mode encoding.
package bpsk_correlator_demod_pkg;

  typedef enum logic {
    MODE_COHERENT     = 1'b0,
    MODE_DIFFERENTIAL = 1'b1
  } decision_mode_e;

  // Product width plus enough growth bits to sum one symbol's worth of products.
  function automatic int unsigned acc_width(input int unsigned sample_width,
                                            input int unsigned amp_width,
                                            input int unsigned samples_per_symbol);
    return sample_width + amp_width + $clog2(samples_per_symbol);
  endfunction

endpackage

// File: rtl/carrier_sine_rom.sv
// Reference-carrier sine table, filled at elaboration, read combinationally by phase.
module carrier_sine_rom #(
  parameter int SAMPLES_PER_SYMBOL = 32,
  parameter int AMP_WIDTH          = 8,
  localparam int unsigned PHASE_WIDTH = $clog2(SAMPLES_PER_SYMBOL)
) (
  input  logic [PHASE_WIDTH-1:0]      phase,
  output logic signed [AMP_WIDTH-1:0] amp
);

  localparam real PI      = 3.14159265358979323846;
  localparam real AMP_MAX = real'((2 ** (AMP_WIDTH - 1)) - 1);

  logic signed [AMP_WIDTH-1:0] rom [SAMPLES_PER_SYMBOL];

  // Round to nearest, ties away from zero.
  for (genvar p = 0; p < SAMPLES_PER_SYMBOL; p++) begin : g_rom
    localparam real VAL = AMP_MAX * $sin(2.0 * PI * real'(p) / real'(SAMPLES_PER_SYMBOL));
    localparam int  RND = (VAL >= 0.0) ? $rtoi(VAL + 0.5) : -$rtoi(0.5 - VAL);
    assign rom[p] = AMP_WIDTH'(RND);
  end

  assign amp = rom[phase];

endmodule

// File: rtl/bpsk_correlator_demod.sv
// Correlates incoming samples against a stored sine carrier over one symbol
// and decides the bit (coherent or differential) into a one-entry output register.
module bpsk_correlator_demod
  import bpsk_correlator_demod_pkg::*;
#(
  parameter int SAMPLE_WIDTH       = 8,
  parameter int AMP_WIDTH          = 8,
  parameter int SAMPLES_PER_SYMBOL = 32,
  parameter int DIFFERENTIAL       = 0,
  localparam int unsigned ACC_WIDTH = acc_width(SAMPLE_WIDTH, AMP_WIDTH, SAMPLES_PER_SYMBOL)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           sample_valid,
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  input  logic                           symbol_start,
  input  logic                           symbol_ready,
  output logic                           symbol_valid,
  output logic                           symbol_bit,
  output logic signed [ACC_WIDTH-1:0]    symbol_metric,
  output logic                           overrun
);

  localparam int unsigned PW = $clog2(SAMPLES_PER_SYMBOL);
  localparam logic [PW-1:0] LAST_PHASE = PW'(SAMPLES_PER_SYMBOL - 1);
  localparam decision_mode_e MODE = (DIFFERENTIAL != 0) ? MODE_DIFFERENTIAL : MODE_COHERENT;

  logic [PW-1:0]                phase;
  logic [PW-1:0]                rom_phase_c;
  logic signed [AMP_WIDTH-1:0]  amp_c;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  prod_c;
  logic signed [ACC_WIDTH-1:0]  total_c;
  logic                         prev_raw;
  logic                         raw_c;
  logic                         bit_c;

  // A resync sample is phase 0 regardless of where the counter was.
  assign rom_phase_c = symbol_start ? '0 : phase;

  carrier_sine_rom #(
    .SAMPLES_PER_SYMBOL (SAMPLES_PER_SYMBOL),
    .AMP_WIDTH          (AMP_WIDTH)
  ) u_rom (
    .phase (rom_phase_c),
    .amp   (amp_c)
  );

  always_comb begin
    prod_c  = ACC_WIDTH'(sample) * ACC_WIDTH'(amp_c);
    total_c = acc + prod_c;
    raw_c   = total_c[ACC_WIDTH-1];
    bit_c   = (MODE == MODE_DIFFERENTIAL) ? (raw_c ^ prev_raw) : raw_c;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase         <= '0;
      acc           <= '0;
      prev_raw      <= 1'b0;
      symbol_valid  <= 1'b0;
      symbol_bit    <= 1'b0;
      symbol_metric <= '0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (symbol_valid && symbol_ready) symbol_valid <= 1'b0;
      if (sample_valid) begin
        if (symbol_start) begin
          phase <= PW'(1);
          acc   <= prod_c;
        end else if (phase == LAST_PHASE) begin
          phase    <= '0;
          acc      <= '0;
          prev_raw <= raw_c;
          // A held, unaccepted symbol wins; the new one is dropped and flagged.
          if (!symbol_valid || symbol_ready) begin
            symbol_valid  <= 1'b1;
            symbol_bit    <= bit_c;
            symbol_metric <= total_c;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          phase <= phase + PW'(1);
          acc   <= total_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_bpsk_correlator_demod.sv
// Self-checking bench: directed scenarios plus random traffic against a
// symbol-level reference model, for coherent and differential instances.
module tb_bpsk_correlator_demod;

  localparam int N    = 32;
  localparam int SW   = 8;
  localparam int AW   = 8;
  localparam int ACCW = SW + AW + $clog2(N);

  logic clock = 1'b0;
  logic reset;
  logic sample_valid;
  logic signed [SW-1:0] sample;
  logic symbol_start;
  logic symbol_ready;

  logic                   c_valid, c_bit, c_ov;
  logic signed [ACCW-1:0] c_metric;
  logic                   d_valid, d_bit, d_ov;
  logic signed [ACCW-1:0] d_metric;

  always #5 clock = ~clock;

  bpsk_correlator_demod #(.SAMPLE_WIDTH(SW), .AMP_WIDTH(AW), .SAMPLES_PER_SYMBOL(N), .DIFFERENTIAL(0)) dut (
    .clock(clock), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .symbol_start(symbol_start), .symbol_ready(symbol_ready),
    .symbol_valid(c_valid), .symbol_bit(c_bit), .symbol_metric(c_metric), .overrun(c_ov));

  bpsk_correlator_demod #(.SAMPLE_WIDTH(SW), .AMP_WIDTH(AW), .SAMPLES_PER_SYMBOL(N), .DIFFERENTIAL(1)) dut_d (
    .clock(clock), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .symbol_start(symbol_start), .symbol_ready(symbol_ready),
    .symbol_valid(d_valid), .symbol_bit(d_bit), .symbol_metric(d_metric), .overrun(d_ov));

  int total = 0;
  int bad   = 0;

  // Reference model state
  int     ref_amp [N];
  int     sin_s   [N];
  int     sbuf    [N];
  int     cnt;
  bit     m_valid, m_bit, m_bit_d, m_ov, m_prev;
  longint m_metric;
  longint m1;
  int     ov_seen;

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".valid"},    longint'(c_valid), longint'(m_valid));
    chk({where, ".overrun"},  longint'(c_ov), longint'(m_ov));
    chk({where, ".bit"},      longint'(c_bit), longint'(m_bit));
    chk({where, ".metric"},   longint'(c_metric), m_metric);
    chk({where, ".d_valid"},  longint'(d_valid), longint'(m_valid));
    chk({where, ".d_bit"},    longint'(d_bit), longint'(m_bit_d));
    chk({where, ".d_metric"}, longint'(d_metric), m_metric);
  endtask

  task automatic model_clear();
    cnt = 0; m_valid = 0; m_bit = 0; m_bit_d = 0; m_ov = 0; m_prev = 0; m_metric = 0;
  endtask

  // One clock of stimulus; the model advances on the same edge as the DUT.
  task automatic step(input bit v, input int s, input bit st, input bit rdy, input string where);
    longint sum;
    bit raw, consumed;
    sample_valid = v; sample = SW'(s); symbol_start = st; symbol_ready = rdy;
    consumed = m_valid && rdy;
    m_ov = 0;
    if (consumed) m_valid = 0;
    if (v) begin
      if (st) begin
        sbuf[0] = s; cnt = 1;
      end else begin
        sbuf[cnt] = s; cnt++;
        if (cnt == N) begin
          sum = 0;
          for (int k = 0; k < N; k++) sum += longint'(sbuf[k]) * longint'(ref_amp[k]);
          raw = (sum < 0);
          cnt = 0;
          if (!(m_valid && !consumed) ) begin
            m_valid = 1; m_bit = raw; m_bit_d = raw ^ m_prev; m_metric = sum;
          end else begin
            m_ov = 1;
          end
          m_prev = raw;
        end
      end
    end
    @(posedge clock);
    #1;
    if (c_ov) ov_seen++;
    check_outputs(where);
  endtask

  task automatic do_reset(input string where);
    reset = 1'b1;
    #2;
    model_clear();
    check_outputs(where);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic send_symbol(input int sgn, input bit toggle, input bit start0, input bit rdy,
                             input string where);
    for (int k = 0; k < N; k++) begin
      if (toggle) step(1'b0, int'($urandom_range(0, 255)) - 128, 1'b0, rdy, where);
      step(1'b1, sgn * sin_s[k], start0 && (k == 0), rdy, where);
    end
  endtask

  initial begin
    int exp_d [4];
    reset = 1'b1;
    sample_valid = 1'b0; sample = '0; symbol_start = 1'b0; symbol_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      ref_amp[k] = rnd(127.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(N)));
      sin_s[k]   = rnd(100.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(N)));
    end
    m1 = 0;
    for (int k = 0; k < N; k++) m1 += longint'(sin_s[k]) * longint'(ref_amp[k]);

    do_reset("reset");

    // Clean sine symbol, then its negation
    send_symbol(1, 1'b0, 1'b0, 1'b1, "sine");
    chk("sine.valid_now", longint'(c_valid), 1);
    chk("sine.metric_pos", longint'(c_metric > 0), 1);
    chk("sine.metric_ref", longint'(c_metric), m1);
    step(1'b0, 0, 1'b0, 1'b1, "drain1");
    send_symbol(-1, 1'b0, 1'b0, 1'b1, "neg");
    chk("neg.bit", longint'(c_bit), 1);
    chk("neg.metric", longint'(c_metric), -m1);
    step(1'b0, 0, 1'b0, 1'b1, "drain2");

    // Same symbol with sample_valid gaps
    send_symbol(1, 1'b1, 1'b0, 1'b1, "gappy");
    chk("gappy.bit", longint'(c_bit), 0);
    chk("gappy.metric", longint'(c_metric), m1);
    step(1'b0, 0, 1'b0, 1'b1, "drain3");

    // Backpressure across two symbols
    ov_seen = 0;
    send_symbol(1, 1'b0, 1'b0, 1'b0, "bp_a");
    send_symbol(-1, 1'b0, 1'b0, 1'b0, "bp_b");
    chk("bp.held_metric", longint'(c_metric), m1);
    chk("bp.held_bit", longint'(c_bit), 0);
    chk("bp.overrun_count", longint'(ov_seen), 1);
    step(1'b0, 0, 1'b0, 1'b1, "bp_drain");
    chk("bp.drained", longint'(c_valid), 0);

    // DBPSK raw sequence 0,1,1,0
    do_reset("reset_d");
    exp_d[0] = 0; exp_d[1] = 1; exp_d[2] = 0; exp_d[3] = 1;
    for (int i = 0; i < 4; i++) begin
      send_symbol((i == 1 || i == 2) ? -1 : 1, 1'b0, 1'b0, 1'b1, "dbpsk");
      chk($sformatf("dbpsk.bit%0d", i), longint'(d_bit), longint'(exp_d[i]));
      step(1'b0, 0, 1'b0, 1'b1, "dbpsk_drain");
    end

    // Reset mid-symbol, then a clean symbol
    for (int k = 0; k < 10; k++) step(1'b1, -sin_s[k], 1'b0, 1'b1, "pre_reset");
    do_reset("reset_mid");
    send_symbol(1, 1'b0, 1'b0, 1'b1, "post_reset");
    chk("post_reset.metric", longint'(c_metric), m1);
    step(1'b0, 0, 1'b0, 1'b1, "drain4");
    send_symbol(0, 1'b0, 1'b0, 1'b1, "zero");
    chk("zero.metric", longint'(c_metric), 0);
    chk("zero.bit", longint'(c_bit), 0);
    step(1'b0, 0, 1'b0, 1'b1, "drain5");

    // Resync after 15 samples of a partial symbol
    for (int k = 0; k < 15; k++) step(1'b1, -sin_s[k], 1'b0, 1'b1, "partial");
    send_symbol(1, 1'b0, 1'b1, 1'b1, "resync");
    chk("resync.valid", longint'(c_valid), 1);
    chk("resync.metric", longint'(c_metric), m1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), int'($urandom_range(0, 255)) - 128,
           ($urandom_range(0, 99) < 3), $urandom_range(0, 1) == 1, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bpsk_correlator_demod.md
BPSK_CORRELATOR_DEMOD -- requirements
Module: bpsk_correlator_demod

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 8: signed input sample width.
REQ-002 Parameter AMP_WIDTH, default 8: signed reference-carrier amplitude width.
REQ-003 Parameter SAMPLES_PER_SYMBOL, default 32: carrier samples per symbol; legal range 4..1024.
REQ-004 Parameter DIFFERENTIAL, default 0: 0 = coherent BPSK decision, 1 = DBPSK decision.
REQ-005 clock  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 sample_valid  in  1  sample is accepted this cycle.
REQ-008 sample  in  SAMPLE_WIDTH signed  received baseband/IF sample.
REQ-009 symbol_start  in  1  resync: a valid sample with this high is phase 0 of a new symbol.
REQ-010 symbol_ready  in  1  downstream accepts symbol_bit this cycle.
REQ-011 symbol_valid  out  1  symbol_bit/symbol_metric hold a decided symbol.
REQ-012 symbol_bit  out  1  decided bit.
REQ-013 symbol_metric  out  ACC_WIDTH signed  full correlation sum for the symbol.
REQ-014 overrun  out  1  one-cycle pulse: a completed symbol was dropped.

Function
REQ-015 Phase counter runs 0..SAMPLES_PER_SYMBOL-1, advances only on sample_valid, and wraps to 0 after the last phase.
REQ-016 Reference amplitude = carrier_sine_rom(phase) = round((2^(AMP_WIDTH-1)-1)*sin(2*pi*phase/SAMPLES_PER_SYMBOL)), combinational.
REQ-017 Each accepted sample adds the full-precision product sample*amp to the accumulator; no truncation and no saturation.
REQ-018 ACC_WIDTH = SAMPLE_WIDTH+AMP_WIDTH+clog2(SAMPLES_PER_SYMBOL); overflow is impossible by construction.
REQ-019 On the sample at the last phase, total = accumulator + that sample's product; the last product is never discarded.
REQ-020 When total is formed, the accumulator restarts at 0 in the same cycle, so no sample is lost between symbols.
REQ-021 Coherent decision: raw = 1 if total < 0, else 0 (total = 0 gives 0).
REQ-022 DIFFERENTIAL=1: symbol_bit = raw XOR previous raw; previous raw is 0 after reset.
REQ-023 Latency: symbol_valid rises the cycle after the last-phase sample is accepted; symbol_metric = total.
REQ-024 Output is a one-entry register: symbol_valid, symbol_bit and symbol_metric hold stable until a cycle with symbol_valid & symbol_ready.
REQ-025 Completion on a cycle where symbol_ready is high and symbol_valid is high loads the new symbol; symbol_valid stays high.
REQ-026 Completion while symbol_valid=1 and symbol_ready=0 drops the new symbol; overrun pulses 1 cycle and the held symbol is unchanged.
REQ-027 In REQ-026 the previous raw bit for DBPSK still updates to the dropped symbol's raw.
REQ-028 sample_valid & symbol_start forces phase 0 and accumulator := that sample's product; any partial symbol is discarded without output.
REQ-029 symbol_start without sample_valid is ignored.

Reset
REQ-030 Reset clears the following immediately and asynchronously: phase=0, accumulator=0, previous raw=0, symbol_valid=0, symbol_bit=0, symbol_metric=0, overrun=0.
REQ-031 Reset mid-symbol discards the partial sum; the first sample accepted after deassertion is phase 0.

Structure
REQ-032 A shared package holds the ACC_WIDTH derivation function and the decision-mode enum (MODE_COHERENT, MODE_DIFFERENTIAL).
REQ-033 Sub-module carrier_sine_rom(SAMPLES_PER_SYMBOL, AMP_WIDTH) is the parametrised table, generated at elaboration; no other sub-modules.

Verification
REQ-034 N=32, sample = round(100*sin(2*pi*k/32)), 32 valid cycles -> symbol_valid next cycle, bit 0, metric > 0; negated input -> bit 1, metric = exact negation.
REQ-035 Same symbol with sample_valid toggling every other cycle (64 cycles) -> identical bit and metric to REQ-034.
REQ-036 symbol_ready=0 across two full symbols -> first symbol held unchanged, overrun pulses exactly once at the second completion.
REQ-037 DIFFERENTIAL=1 with raw sequence 0,1,1,0 -> symbol_bit 0,1,0,1.
REQ-038 Reset asserted after 10 samples, then 32 samples -> exactly one symbol, metric equals the clean-run value; all-zero input -> metric 0, bit 0.
REQ-039 symbol_start with sample 15 of a symbol -> no output for the partial symbol; the next 32 samples give a correct symbol.
